// File: rtl/sys_tx_ctrl.sv
// sys_tx_ctrl: arbitrates ALU results (two bytes) and register-file reads
// (one byte) onto a single UART transmitter. Each source has a one-deep
// holding register; a request arriving while its holding register is still
// occupied is dropped and flagged on OVERRUN.
//
// Transmitter handshake: TX_VLD is a one-cycle strobe with TX_DATA valid in
// the same cycle. The transmitter acknowledges by raising TX_BUSY and signals
// completion by dropping it again. The next strobe is only issued after that
// fall has been seen.
module sys_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ALU_SEND,
    input  logic [2*DATA_WIDTH-1:0] ALU_DATA,
    input  logic                    RF_SEND,
    input  logic [DATA_WIDTH-1:0]   RF_DATA,
    input  logic                    TX_BUSY,
    input  logic                    OVR_CLR,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_VLD,
    output logic                    BUSY,
    output logic                    OVERRUN,
    output logic [1:0]              state_dbg
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] TX_REQ     = 2'd1;
    localparam logic [1:0] WAIT_START = 2'd2;
    localparam logic [1:0] WAIT_DONE  = 2'd3;

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic                    pend_alu;
    logic                    pend_rf;
    logic [2*DATA_WIDTH-1:0] hold_alu;
    logic [DATA_WIDTH-1:0]   hold_rf;
    logic [2*DATA_WIDTH-1:0] tx_buf;
    logic [1:0]              byte_cnt;
    logic                    prio_rf;

    logic grant_any;
    logic grant_alu;
    logic grant_rf;
    logic contended;
    logic drop_alu;
    logic drop_rf;
    logic take_alu;
    logic take_rf;
    logic byte_done;

    // Grant, drop and capture decisions for the coming edge. A source that is
    // granted on this edge frees its holding register, so a SEND on the same
    // edge is captured rather than dropped.
    always_comb begin
        grant_any = (state == IDLE) && (pend_alu || pend_rf) && !TX_BUSY;
        contended = pend_alu && pend_rf;
        grant_alu = grant_any && pend_alu && (!pend_rf || !prio_rf);
        grant_rf  = grant_any && !grant_alu;
        drop_alu  = ALU_SEND && pend_alu && !grant_alu;
        drop_rf   = RF_SEND && pend_rf && !grant_rf;
        take_alu  = ALU_SEND && !drop_alu;
        take_rf   = RF_SEND && !drop_rf;
        byte_done = (state == WAIT_DONE) && !TX_BUSY;
    end

    // Next-state logic of the transmit sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (grant_any) state_nxt = TX_REQ;
            TX_REQ:     state_nxt = WAIT_START;
            WAIT_START: if (TX_BUSY) state_nxt = WAIT_DONE;
            WAIT_DONE:  if (!TX_BUSY) state_nxt = (byte_cnt > 2'd1) ? TX_REQ : IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Per-source holding registers and pending bits.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pend_alu <= 1'b0;
            pend_rf  <= 1'b0;
            hold_alu <= '0;
            hold_rf  <= '0;
        end else begin
            pend_alu <= take_alu || (pend_alu && !grant_alu);
            pend_rf  <= take_rf || (pend_rf && !grant_rf);
            if (take_alu) hold_alu <= ALU_DATA;
            if (take_rf)  hold_rf  <= RF_DATA;
        end
    end

    // Round-robin pointer; it only moves when both sources competed, so an
    // uncontended grant does not disturb the fairness order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                        prio_rf <= 1'b0;
        else if (grant_any && contended) prio_rf <= grant_alu;
    end

    // Transmit buffer, byte count and the byte presented to the UART.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_buf   <= '0;
            byte_cnt <= 2'd0;
            TX_DATA  <= '0;
        end else if (grant_any) begin
            tx_buf   <= grant_alu ? hold_alu : {{DATA_WIDTH{1'b0}}, hold_rf};
            byte_cnt <= grant_alu ? 2'd2 : 2'd1;
            TX_DATA  <= grant_alu ? hold_alu[DATA_WIDTH-1:0] : hold_rf;
        end else if (byte_done) begin
            byte_cnt <= byte_cnt - 2'd1;
            if (byte_cnt > 2'd1) TX_DATA <= tx_buf[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    // Sticky drop flag; a drop on the same edge as a clear wins.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                      OVERRUN <= 1'b0;
        else if (drop_alu || drop_rf)  OVERRUN <= 1'b1;
        else if (OVR_CLR)              OVERRUN <= 1'b0;
    end

    assign TX_VLD    = (state == TX_REQ);
    assign BUSY      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sys_tx_ctrl.sv
// Bench for sys_tx_ctrl: directed scenarios plus a randomized run, all checked
// cycle by cycle against a transaction-level reference model (byte queues and
// pending flags) and, for the directed cases, against fixed expected bytes.
module tb_sys_tx_ctrl;

  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          alu_send = 1'b0;
  logic [2*DW-1:0] alu_data = '0;
  logic          rf_send = 1'b0;
  logic [DW-1:0] rf_data = '0;
  logic          tx_busy = 1'b0;
  logic          ovr_clr = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_vld;
  logic          busy;
  logic          overrun;
  logic [1:0]    state_dbg;

  sys_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK(clk), .RST(rst),
    .ALU_SEND(alu_send), .ALU_DATA(alu_data),
    .RF_SEND(rf_send), .RF_DATA(rf_data),
    .TX_BUSY(tx_busy), .OVR_CLR(ovr_clr),
    .TX_DATA(tx_data), .TX_VLD(tx_vld), .BUSY(busy), .OVERRUN(overrun),
    .state_dbg(state_dbg)
  );

  // ---------------- counters / scoreboard ----------------
  int n_total = 0;
  int n_bad = 0;
  int strobe_cnt = 0;
  bit sb_on = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each source: a pending flag and its held word. The active job is a queue
  // of bytes still to go; the front byte is the one on the wire.
  bit m_pa, m_pr, m_active, m_vld, m_wait_rise, m_rf_first, m_ovr;
  logic [2*DW-1:0] m_ha;
  logic [DW-1:0]   m_hr, m_data;
  logic [DW-1:0]   job_q[$];

  task automatic model_reset();
    m_pa = 0; m_pr = 0; m_active = 0; m_vld = 0; m_wait_rise = 0;
    m_rf_first = 0; m_ovr = 0; m_ha = '0; m_hr = '0; m_data = '0;
    job_q.delete();
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    bit ga, gr, drop;
    logic [DW-1:0] tmp;
    ga = 0; gr = 0; drop = 0;
    if (!m_active) begin
      if ((m_pa || m_pr) && !tx_busy) begin
        ga = m_pa && (!m_pr || !m_rf_first);
        gr = !ga;
        if (m_pa && m_pr) m_rf_first = ga;
        job_q.delete();
        if (ga) begin
          job_q.push_back(m_ha[DW-1:0]);
          job_q.push_back(m_ha[2*DW-1:DW]);
          m_pa = 0;
        end else begin
          job_q.push_back(m_hr);
          m_pr = 0;
        end
        m_active = 1; m_vld = 1; m_data = job_q[0];
      end
    end else if (m_vld) begin
      m_vld = 0; m_wait_rise = 1;
    end else if (m_wait_rise) begin
      if (tx_busy) m_wait_rise = 0;
    end else if (!tx_busy) begin
      tmp = job_q.pop_front();
      if (job_q.size() > 0) begin
        m_vld = 1; m_data = job_q[0];
      end else begin
        m_active = 0;
      end
    end
    if (alu_send) begin
      if (m_pa) drop = 1;
      else begin m_pa = 1; m_ha = alu_data; end
    end
    if (rf_send) begin
      if (m_pr) drop = 1;
      else begin m_pr = 1; m_hr = rf_data; end
    end
    if (drop) m_ovr = 1;
    else if (ovr_clr) m_ovr = 0;
  endtask

  // ---------------- UART transmitter model ----------------
  int u_delay = 0, u_len = 0, u_len_cfg = 10, ext_cnt = 0;
  bit rand_len = 0, ext_en = 0, force_busy = 0;

  task automatic uart_update(input bit strobe);
    bit ub;
    if (strobe) begin
      u_delay = $urandom_range(0, 2);
      u_len = rand_len ? $urandom_range(2, 6) : u_len_cfg;
    end
    if (ext_cnt > 0) ext_cnt--;
    else if (ext_en && u_delay == 0 && u_len == 0 && $urandom_range(0, 15) == 0)
      ext_cnt = $urandom_range(1, 4);
    if (u_delay > 0) begin u_delay--; ub = 0; end
    else if (u_len > 0) begin u_len--; ub = 1; end
    else ub = 0;
    tx_busy = ub | (ext_cnt > 0) | force_busy;
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model steps with the applied inputs, outputs compared at the
  // falling edge, then the UART and pulse inputs are updated for the next one.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_eq("tx_vld", {31'b0, tx_vld}, {31'b0, m_vld});
    check_eq("busy", {31'b0, busy}, {31'b0, m_active});
    check_eq("overrun", {31'b0, overrun}, {31'b0, m_ovr});
    check_eq("tx_data", {24'b0, tx_data}, {24'b0, m_data});
    if (tx_vld) begin
      strobe_cnt++;
      if (sb_on) begin
        if (exp_q.size() > 0) check_eq("sb_byte", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
        else check_eq("sb_unexpected_strobe", {31'b0, tx_vld}, 32'd0);
      end
    end
    uart_update(m_vld);
    alu_send = 0; rf_send = 0; ovr_clr = 0;
  endtask

  task automatic cyc(input bit as, input logic [2*DW-1:0] ad, input bit rs,
                     input logic [DW-1:0] rd, input bit clr);
    alu_send = as; alu_data = ad; rf_send = rs; rf_data = rd; ovr_clr = clr;
    step();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    while ((m_active || m_pa || m_pr || u_len > 0 || u_delay > 0 || ext_cnt > 0) && k < max_cyc) begin
      step();
      k++;
    end
    check_eq("wait_idle", {31'b0, m_active | m_pa | m_pr}, 32'd0);
  endtask

  task automatic apply_reset();
    rst = 0;
    #1;
    model_reset();
    u_delay = 0; u_len = 0; ext_cnt = 0; force_busy = 0; tx_busy = 0;
    alu_send = 0; rf_send = 0; ovr_clr = 0;
    check_eq("rst_tx_vld", {31'b0, tx_vld}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_overrun", {31'b0, overrun}, 32'd0);
    check_eq("rst_tx_data", {24'b0, tx_data}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic sb_done(input string tag);
    check_eq(tag, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    int k;
    model_reset();
    @(negedge clk);
    apply_reset();
    sb_on = 1;

    // Single RF byte: strobe two cycles after the request, then idle again.
    exp_q.push_back(8'h5A);
    cyc(0, '0, 1, 8'h5A, 0);
    check_eq("lat_n1", {31'b0, tx_vld}, 32'd0);
    step();
    check_eq("lat_n2_vld", {31'b0, tx_vld}, 32'd1);
    check_eq("lat_n2_data", {24'b0, tx_data}, 32'h5A);
    wait_idle(100);
    check_eq("rf_busy_end", {31'b0, busy}, 32'd0);
    check_eq("rf_ovr", {31'b0, overrun}, 32'd0);
    sb_done("rf_single_left");

    // ALU word: low byte then high byte, exactly two strobes.
    s0 = strobe_cnt;
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    cyc(1, 16'h1234, 0, '0, 0);
    wait_idle(200);
    check_eq("alu_strobes", strobe_cnt - s0, 32'd2);
    check_eq("alu_tx_data_hold", {24'b0, tx_data}, 32'h12);
    sb_done("alu_left");

    // Simultaneous requests after reset: ALU first; next pair: RF first.
    apply_reset();
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE); exp_q.push_back(8'h77);
    cyc(1, 16'hBEEF, 1, 8'h77, 0);
    wait_idle(300);
    sb_done("rr_pair1_left");
    exp_q.push_back(8'h33); exp_q.push_back(8'h02); exp_q.push_back(8'h01);
    cyc(1, 16'h0102, 1, 8'h33, 0);
    wait_idle(300);
    sb_done("rr_pair2_left");

    // Second RF request before the first is granted is dropped.
    exp_q.push_back(8'h66); exp_q.push_back(8'h55); exp_q.push_back(8'h11);
    cyc(1, 16'h5566, 0, '0, 0);
    idle_cycles(3);
    cyc(0, '0, 1, 8'h11, 0);
    idle_cycles(2);
    cyc(0, '0, 1, 8'h22, 0);
    check_eq("drop_ovr_set", {31'b0, overrun}, 32'd1);
    wait_idle(300);
    sb_done("drop_left");
    check_eq("ovr_sticky", {31'b0, overrun}, 32'd1);
    cyc(0, '0, 0, '0, 1);
    check_eq("ovr_cleared", {31'b0, overrun}, 32'd0);

    // Drop on the same edge as the clear keeps OVERRUN set.
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'h44);
    cyc(1, 16'hA2A1, 0, '0, 0);
    idle_cycles(2);
    cyc(0, '0, 1, 8'h44, 0);
    cyc(0, '0, 1, 8'h45, 1);
    check_eq("drop_vs_clr", {31'b0, overrun}, 32'd1);
    wait_idle(300);
    sb_done("drop_clr_left");
    cyc(0, '0, 0, '0, 1);

    // Reset while the first ALU byte is in flight: aborts everything.
    exp_q.push_back(8'hCD);
    cyc(1, 16'hABCD, 0, '0, 0);
    cyc(0, '0, 1, 8'h99, 0);
    k = 0;
    while (!(m_active && !m_vld && !m_wait_rise && job_q.size() == 2) && k < 50) begin
      step();
      k++;
    end
    check_eq("reach_wait_done", k < 50, 32'd1);
    apply_reset();
    sb_done("abort_left");
    s0 = strobe_cnt;
    idle_cycles(40);
    check_eq("no_strobe_after_abort", strobe_cnt - s0, 32'd0);
    check_eq("abort_idle_busy", {31'b0, busy}, 32'd0);

    // TX_BUSY held high while RF waits: no grant until it falls.
    force_busy = 1; tx_busy = 1;
    exp_q.push_back(8'h3C);
    s0 = strobe_cnt;
    cyc(0, '0, 1, 8'h3C, 0);
    idle_cycles(8);
    check_eq("held_busy_no_strobe", strobe_cnt - s0, 32'd0);
    force_busy = 0; tx_busy = 0;
    step();
    check_eq("busy_fall_vld", {31'b0, tx_vld}, 32'd1);
    check_eq("busy_fall_data", {24'b0, tx_data}, 32'h3C);
    wait_idle(100);
    sb_done("held_busy_left");

    // Randomized traffic checked against the model only.
    sb_on = 0; rand_len = 1; ext_en = 1;
    for (int i = 0; i < 1500; i++) begin
      alu_send = ($urandom_range(0, 7) == 0);
      alu_data = 16'($urandom);
      rf_send = ($urandom_range(0, 5) == 0);
      rf_data = 8'($urandom);
      ovr_clr = ($urandom_range(0, 19) == 0);
      step();
    end
    ext_en = 0;
    wait_idle(500);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
